wb_stage: RTL and testbench

Writeback stage of the NPC pipeline. It sits between the memory stage and the commit-trace/DPI block. It accepts one instruction per cycle from the memory stage through a valid/allowin handshake. It retires that instruction to the register file, drives the forwarding path back to decode, and produces the debug commit signals (ws_valid, debug_wb_*, stop) that the trace block samples. It also owns the halt latch for ebreak and the retired-instruction counter.

---
 rtl/wb_stage.sv | 113 +++++++++++
 tb/tb_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage: retires one instruction per cycle to the register
//            file, forwarding path and commit trace; owns ebreak halt and instret.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
   parameter int PC_WD      = 64,
   parameter int INST_WD    = 32,
   parameter int RF_ADDR_WD = 5,
   parameter int RF_DATA_WD = 64,
   parameter int CNT_WD     = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ms_to_ws_valid,
   input  logic [PC_WD-1:0]      ms_pc,
   input  logic [INST_WD-1:0]    ms_inst,
   input  logic                  ms_rf_wen,
   input  logic [RF_ADDR_WD-1:0] ms_rf_waddr,
   input  logic [RF_DATA_WD-1:0] ms_rf_wdata,
   input  logic                  ms_ebreak,
   output logic                  ws_allowin,
   output logic                  rf_we,
   output logic [RF_ADDR_WD-1:0] rf_waddr,
   output logic [RF_DATA_WD-1:0] rf_wdata,
   output logic                  ws_fwd_valid,
   output logic [RF_ADDR_WD-1:0] ws_fwd_addr,
   output logic [RF_DATA_WD-1:0] ws_fwd_data,
   output logic                  ws_valid,
   output logic [PC_WD-1:0]      debug_wb_pc,
   output logic [INST_WD-1:0]    debug_wb_inst,
   output logic                  debug_wb_rf_wen,
   output logic [RF_ADDR_WD-1:0] debug_wb_rf_wnum,
   output logic [RF_DATA_WD-1:0] debug_wb_rf_wdata,
   output logic                  stop,
   output logic [CNT_WD-1:0]     instret
);

   localparam logic c_WS_READY_GO = 1'b1;

   logic                  r_ws_valid;
   logic [PC_WD-1:0]      r_pc;
   logic [INST_WD-1:0]    r_inst;
   logic                  r_rf_wen;
   logic [RF_ADDR_WD-1:0] r_rf_waddr;
   logic [RF_DATA_WD-1:0] r_rf_wdata;
   logic                  r_ebreak;
   logic                  r_halted;
   logic [CNT_WD-1:0]     r_instret;

   logic w_ws_allowin;
   logic w_halt_now;
   logic w_rf_we;

   assign w_ws_allowin = !r_halted && (!r_ws_valid || c_WS_READY_GO);
   assign w_halt_now   = r_ws_valid && r_ebreak;
   assign w_rf_we      = r_ws_valid && r_rf_wen && (r_rf_waddr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ws_valid <= 1'b0;
         r_pc       <= '0;
         r_inst     <= '0;
         r_rf_wen   <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_ebreak   <= 1'b0;
         r_halted   <= 1'b0;
         r_instret  <= '0;
      end else begin
         if (w_ws_allowin) begin
            // An instruction accepted alongside a retiring ebreak never becomes valid.
            r_ws_valid <= ms_to_ws_valid && !w_halt_now;
            if (ms_to_ws_valid) begin
               r_pc       <= ms_pc;
               r_inst     <= ms_inst;
               r_rf_wen   <= ms_rf_wen;
               r_rf_waddr <= ms_rf_waddr;
               r_rf_wdata <= ms_rf_wdata;
               r_ebreak   <= ms_ebreak;
            end
         end else begin
            r_ws_valid <= 1'b0;
         end
         if (w_halt_now) begin
            r_halted <= 1'b1;
         end
         if (r_ws_valid) begin
            r_instret <= r_instret + CNT_WD'(1);
         end
      end
   end

   assign ws_allowin        = w_ws_allowin;
   assign rf_we             = w_rf_we;
   assign rf_waddr          = r_rf_waddr;
   assign rf_wdata          = r_rf_wdata;
   assign ws_fwd_valid      = w_rf_we;
   assign ws_fwd_addr       = r_rf_waddr;
   assign ws_fwd_data       = r_rf_wdata;
   assign ws_valid          = r_ws_valid;
   assign debug_wb_pc       = r_pc;
   assign debug_wb_inst     = r_inst;
   assign debug_wb_rf_wen   = w_rf_we;
   assign debug_wb_rf_wnum  = r_rf_waddr;
   assign debug_wb_rf_wdata = r_rf_wdata;
   assign stop              = r_halted;
   assign instret           = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        ms_to_ws_valid;
   logic [63:0] ms_pc;
   logic [31:0] ms_inst;
   logic        ms_rf_wen;
   logic [4:0]  ms_rf_waddr;
   logic [63:0] ms_rf_wdata;
   logic        ms_ebreak;
   logic        ws_allowin;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        ws_fwd_valid;
   logic [4:0]  ws_fwd_addr;
   logic [63:0] ws_fwd_data;
   logic        ws_valid;
   logic [63:0] debug_wb_pc;
   logic [31:0] debug_wb_inst;
   logic        debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [63:0] debug_wb_rf_wdata;
   logic        stop;
   logic [63:0] instret;

   int n_checks = 0;
   int n_pass   = 0;

   wb_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ms_to_ws_valid   (ms_to_ws_valid),
      .ms_pc            (ms_pc),
      .ms_inst          (ms_inst),
      .ms_rf_wen        (ms_rf_wen),
      .ms_rf_waddr      (ms_rf_waddr),
      .ms_rf_wdata      (ms_rf_wdata),
      .ms_ebreak        (ms_ebreak),
      .ws_allowin       (ws_allowin),
      .rf_we            (rf_we),
      .rf_waddr         (rf_waddr),
      .rf_wdata         (rf_wdata),
      .ws_fwd_valid     (ws_fwd_valid),
      .ws_fwd_addr      (ws_fwd_addr),
      .ws_fwd_data      (ws_fwd_data),
      .ws_valid         (ws_valid),
      .debug_wb_pc      (debug_wb_pc),
      .debug_wb_inst    (debug_wb_inst),
      .debug_wb_rf_wen  (debug_wb_rf_wen),
      .debug_wb_rf_wnum (debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .stop             (stop),
      .instret          (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                        input logic wen, input logic [4:0] waddr, input logic [63:0] wdata,
                        input logic ebrk);
      ms_to_ws_valid = v;
      ms_pc          = pc;
      ms_inst        = inst;
      ms_rf_wen      = wen;
      ms_rf_waddr    = waddr;
      ms_rf_wdata    = wdata;
      ms_ebreak      = ebrk;
   endtask

   task automatic idle();
      drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'h0, 1'b0);
      step();
      step();
      n_checks++; if (ws_valid !== 1'b0) $display("FAIL reset_ws_valid: got %b want 0", ws_valid); else n_pass++;
      n_checks++; if (stop !== 1'b0) $display("FAIL reset_stop: got %b want 0", stop); else n_pass++;
      n_checks++; if (instret !== 64'd0) $display("FAIL reset_instret: got %0d want 0", instret); else n_pass++;
      n_checks++; if (ws_allowin !== 1'b1) $display("FAIL reset_allowin: got %b want 1", ws_allowin); else n_pass++;
      n_checks++; if (debug_wb_pc !== 64'h0) $display("FAIL reset_pc: got %h want 0", debug_wb_pc); else n_pass++;
      rst_n = 1'b1;
      step();
      n_checks++; if (debug_wb_pc !== 64'h8000_0000) $display("FAIL reset_first_pc: got %h want 80000000", debug_wb_pc); else n_pass++;
      n_checks++; if (ws_valid !== 1'b1) $display("FAIL reset_first_valid: got %b want 1", ws_valid); else n_pass++;
      idle();
      step();
      n_checks++; if (instret !== 64'd1) $display("FAIL reset_first_retire: got %0d want 1", instret); else n_pass++;
   endtask

   task automatic test_single_write();
      drive(1'b1, 64'h8000_0004, 32'h2340_0293, 1'b1, 5'd5, 64'h1234, 1'b0);
      step();
      n_checks++; if (rf_we !== 1'b1) $display("FAIL write_rf_we: got %b want 1", rf_we); else n_pass++;
      n_checks++; if (rf_waddr !== 5'd5) $display("FAIL write_waddr: got %0d want 5", rf_waddr); else n_pass++;
      n_checks++; if (rf_wdata !== 64'h1234) $display("FAIL write_wdata: got %h want 1234", rf_wdata); else n_pass++;
      n_checks++; if (ws_fwd_valid !== 1'b1 || ws_fwd_addr !== 5'd5 || ws_fwd_data !== 64'h1234)
         $display("FAIL write_fwd: got %b/%0d/%h want 1/5/1234", ws_fwd_valid, ws_fwd_addr, ws_fwd_data); else n_pass++;
      n_checks++; if (debug_wb_rf_wen !== 1'b1 || debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 64'h1234)
         $display("FAIL write_debug_rf: got %b/%0d/%h want 1/5/1234", debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata); else n_pass++;
      n_checks++; if (debug_wb_pc !== 64'h8000_0004 || debug_wb_inst !== 32'h2340_0293)
         $display("FAIL write_debug_pc: got %h/%h want 80000004/23400293", debug_wb_pc, debug_wb_inst); else n_pass++;
      idle();
      step();
      n_checks++; if (instret !== 64'd2) $display("FAIL write_instret: got %0d want 2", instret); else n_pass++;
      n_checks++; if (rf_we !== 1'b0 || ws_valid !== 1'b0) $display("FAIL write_drain: got we=%b valid=%b want 0/0", rf_we, ws_valid); else n_pass++;
   endtask

   task automatic test_x0_suppress();
      drive(1'b1, 64'h8000_0008, 32'h0000_0013, 1'b1, 5'd0, 64'hdead, 1'b0);
      step();
      n_checks++; if (rf_we !== 1'b0) $display("FAIL x0_rf_we: got %b want 0", rf_we); else n_pass++;
      n_checks++; if (debug_wb_rf_wen !== 1'b0) $display("FAIL x0_debug_wen: got %b want 0", debug_wb_rf_wen); else n_pass++;
      n_checks++; if (ws_fwd_valid !== 1'b0) $display("FAIL x0_fwd_valid: got %b want 0", ws_fwd_valid); else n_pass++;
      n_checks++; if (ws_valid !== 1'b1) $display("FAIL x0_ws_valid: got %b want 1", ws_valid); else n_pass++;
      n_checks++; if (rf_wdata !== 64'hdead) $display("FAIL x0_wdata: got %h want dead", rf_wdata); else n_pass++;
      idle();
      step();
      n_checks++; if (instret !== 64'd3) $display("FAIL x0_instret: got %0d want 3", instret); else n_pass++;
   endtask

   task automatic test_bubbles();
      logic [3:0] pattern;
      pattern = 4'b1011;  // bit i is the valid for slot i: 1,1,0,1
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(pattern[i], 64'h8000_1000 + 64'(4 * i), 32'h0000_0013, 1'b1, 5'(i + 1), 64'(i), 1'b0);
         else idle();
         step();
         if (i < 4) begin
            n_checks++; if (ws_valid !== pattern[i]) $display("FAIL bubble_valid_%0d: got %b want %b", i, ws_valid, pattern[i]); else n_pass++;
            if (pattern[i]) begin
               n_checks++; if (debug_wb_pc !== 64'h8000_1000 + 64'(4 * i))
                  $display("FAIL bubble_pc_%0d: got %h want %h", i, debug_wb_pc, 64'h8000_1000 + 64'(4 * i)); else n_pass++;
            end
         end
      end
      n_checks++; if (instret !== 64'd3) $display("FAIL bubble_instret: got %0d want 3", instret); else n_pass++;
   endtask

   task automatic test_ebreak();
      do_reset();
      drive(1'b1, 64'h8000_2000, 32'h0010_0093, 1'b1, 5'd1, 64'h1, 1'b0);
      step();
      drive(1'b1, 64'h8000_2004, 32'h0010_0073, 1'b0, 5'd0, 64'h0, 1'b1);
      step();
      n_checks++; if (ws_valid !== 1'b1 || stop !== 1'b0 || debug_wb_inst !== 32'h0010_0073)
         $display("FAIL ebreak_retiring: got valid=%b stop=%b inst=%h want 1/0/00100073", ws_valid, stop, debug_wb_inst); else n_pass++;
      drive(1'b1, 64'h8000_2008, 32'h0020_0113, 1'b1, 5'd2, 64'h2, 1'b0);
      step();
      n_checks++; if (stop !== 1'b1) $display("FAIL ebreak_stop: got %b want 1", stop); else n_pass++;
      n_checks++; if (ws_allowin !== 1'b0 || ws_valid !== 1'b0 || rf_we !== 1'b0)
         $display("FAIL ebreak_halted: got allowin=%b valid=%b we=%b want 0/0/0", ws_allowin, ws_valid, rf_we); else n_pass++;
      n_checks++; if (instret !== 64'd2) $display("FAIL ebreak_instret: got %0d want 2", instret); else n_pass++;
      drive(1'b1, 64'h8000_200c, 32'h0030_0193, 1'b1, 5'd3, 64'h3, 1'b0);
      step();
      step();
      n_checks++; if (ws_valid !== 1'b0 || stop !== 1'b1 || instret !== 64'd2)
         $display("FAIL ebreak_frozen: got valid=%b stop=%b instret=%0d want 0/1/2", ws_valid, stop, instret); else n_pass++;
      idle();
      rst_n = 1'b0;
      #1;
      n_checks++; if (stop !== 1'b0 || ws_allowin !== 1'b1) $display("FAIL ebreak_reset: got stop=%b allowin=%b want 0/1", stop, ws_allowin); else n_pass++;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 64'h8000_3000 + 64'(4 * i), 32'h0000_0013, 1'b1, 5'd10, 64'(100 + i), 1'b0);
         step();
         n_checks++; if (ws_valid !== 1'b1 || rf_wdata !== 64'(100 + i))
            $display("FAIL b2b_%0d: got valid=%b data=%0d want 1/%0d", i, ws_valid, rf_wdata, 100 + i); else n_pass++;
      end
      idle();
      step();
      n_checks++; if (instret !== 64'd5) $display("FAIL b2b_instret: got %0d want 5", instret); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 64'h8000_4000, 32'h0550_0393, 1'b1, 5'd7, 64'h55, 1'b0);
      step();
      step();
      n_checks++; if (ws_valid !== 1'b1 || rf_we !== 1'b1 || instret !== 64'd1)
         $display("FAIL async_pre: got valid=%b we=%b instret=%0d want 1/1/1", ws_valid, rf_we, instret); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (ws_valid !== 1'b0 || rf_we !== 1'b0 || instret !== 64'd0)
         $display("FAIL async_drop: got valid=%b we=%b instret=%0d want 0/0/0", ws_valid, rf_we, instret); else n_pass++;
      idle();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_single_write();
      test_x0_suppress();
      test_bubbles();
      test_ebreak();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
